// File: rtl/rtc_bus_ctrl_if.sv
// Request/response handshake between the RTC control FSM (master) and the
// multiplexed-bus controller (slave).
interface rtc_bus_ctrl_if;
    logic       req;
    logic       wr;
    logic [7:0] addr;
    logic [7:0] wdata;
    logic       busy;
    logic       done;
    logic [7:0] rd_data;

    modport master (
        output req, wr, addr, wdata,
        input  busy, done, rd_data
    );

    modport slave (
        input  req, wr, addr, wdata,
        output busy, done, rd_data
    );
endinterface

// File: rtl/rtc_bus_ctrl.sv
// Strobe sequencer for the RTC chip's multiplexed address/data port: address phase
// (A_D low, write strobe) followed by a data phase (A_D high, read or write strobe).
module rtc_bus_ctrl #(
    parameter int unsigned T_SET = 2,
    parameter int unsigned T_STB = 10
) (
    input  logic          clk_100MHz,
    input  logic          rst_n,
    rtc_bus_ctrl_if.slave host,
    input  logic [7:0]    ADin,
    output logic [7:0]    ADout,
    output logic          ad_oe,
    output logic          C_S,
    output logic          R_D,
    output logic          W_R,
    output logic          A_D
);

    typedef enum logic [2:0] {
        StIdle, StAdrSet, StAdrStb, StAdrHld, StGap, StDatStb, StDatHld, StDone
    } state_e;

    localparam logic [7:0] SetLen = 8'(T_SET - 1);
    localparam logic [7:0] StbLen = 8'(T_STB - 1);

    state_e     state_q, state_d;
    logic [7:0] cnt_q, cnt_d;
    logic       wr_q, wr_d;
    logic [7:0] addr_q, addr_d;
    logic [7:0] wdata_q, wdata_d;

    logic       c_s_d, r_d_d, w_r_d, a_d_d, ad_oe_d, busy_d, done_d;
    logic [7:0] ad_out_d, rd_data_d;
    logic       busy_q, done_q;
    logic [7:0] rd_data_q;

    assign host.busy    = busy_q;
    assign host.done    = done_q;
    assign host.rd_data = rd_data_q;

    // State register; pin outputs are registered from the next-state decode.
    always_ff @(posedge clk_100MHz or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= StIdle;
            cnt_q     <= 8'h00;
            wr_q      <= 1'b0;
            addr_q    <= 8'h00;
            wdata_q   <= 8'h00;
            C_S       <= 1'b1;
            R_D       <= 1'b1;
            W_R       <= 1'b1;
            A_D       <= 1'b1;
            ad_oe     <= 1'b0;
            ADout     <= 8'h00;
            busy_q    <= 1'b0;
            done_q    <= 1'b0;
            rd_data_q <= 8'h00;
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            wr_q      <= wr_d;
            addr_q    <= addr_d;
            wdata_q   <= wdata_d;
            C_S       <= c_s_d;
            R_D       <= r_d_d;
            W_R       <= w_r_d;
            A_D       <= a_d_d;
            ad_oe     <= ad_oe_d;
            ADout     <= ad_out_d;
            busy_q    <= busy_d;
            done_q    <= done_d;
            rd_data_q <= rd_data_d;
        end
    end

    always_comb begin
        state_d = state_q;
        wr_d    = wr_q;
        addr_d  = addr_q;
        wdata_d = wdata_q;
        unique case (state_q)
            StIdle: begin
                if (host.req) begin
                    state_d = StAdrSet;
                    wr_d    = host.wr;
                    addr_d  = host.addr;
                    wdata_d = host.wdata;
                end
            end
            StAdrSet: if (cnt_q == 8'h00) state_d = StAdrStb;
            StAdrStb: if (cnt_q == 8'h00) state_d = StAdrHld;
            StAdrHld: if (cnt_q == 8'h00) state_d = StGap;
            StGap:    if (cnt_q == 8'h00) state_d = StDatStb;
            StDatStb: if (cnt_q == 8'h00) state_d = StDatHld;
            StDatHld: if (cnt_q == 8'h00) state_d = StDone;
            StDone:   state_d = StIdle;
            default:  state_d = StIdle;
        endcase

        // Phase counter reloads on every state entry and otherwise counts down to 0.
        cnt_d = cnt_q;
        if (state_d != state_q) begin
            unique case (state_d)
                StAdrStb, StDatStb: cnt_d = StbLen;
                StIdle, StDone:     cnt_d = 8'h00;
                default:            cnt_d = SetLen;
            endcase
        end else if (cnt_q != 8'h00) begin
            cnt_d = cnt_q - 8'd1;
        end
    end

    always_comb begin
        c_s_d     = 1'b1;
        r_d_d     = 1'b1;
        w_r_d     = 1'b1;
        a_d_d     = 1'b1;
        ad_oe_d   = 1'b0;
        ad_out_d  = 8'h00;
        busy_d    = 1'b1;
        done_d    = 1'b0;
        rd_data_d = rd_data_q;
        unique case (state_d)
            StIdle: busy_d = 1'b0;
            StAdrSet, StAdrHld: begin
                a_d_d    = 1'b0;
                ad_oe_d  = 1'b1;
                ad_out_d = addr_d;
            end
            StAdrStb: begin
                a_d_d    = 1'b0;
                ad_oe_d  = 1'b1;
                ad_out_d = addr_d;
                c_s_d    = 1'b0;
                w_r_d    = 1'b0;
            end
            // For reads the pad is released here so the chip can drive the bus.
            StGap, StDatHld: begin
                ad_oe_d  = wr_d;
                ad_out_d = wr_d ? wdata_d : 8'h00;
            end
            StDatStb: begin
                ad_oe_d  = wr_d;
                ad_out_d = wr_d ? wdata_d : 8'h00;
                c_s_d    = 1'b0;
                w_r_d    = ~wr_d;
                r_d_d    = wr_d;
            end
            StDone: done_d = 1'b1;
            default: busy_d = 1'b0;
        endcase

        // Sample on the edge leaving the strobe, while R_D is still low.
        if (state_q == StDatStb && state_d != StDatStb && !wr_q) begin
            rd_data_d = ADin;
        end
    end

endmodule

// File: tb/tb_rtc_bus_ctrl.sv
// Scoreboard bench for rtc_bus_ctrl: randomized transactions, expected strobes and
// completions queued at issue time, checked by independent monitors.
module tb_rtc_bus_ctrl;
    localparam int TS   = 2;
    localparam int TSB  = 10;
    localparam int TXN  = 4 * TS + 2 * TSB;
    localparam int CAP  = 3 * TS + 2 * TSB;
    localparam int TS2  = 1;
    localparam int TSB2 = 3;
    localparam int TXN2 = 4 * TS2 + 2 * TSB2;

    typedef struct {
        int         done_cyc;
        logic [7:0] rd;
    } done_t;

    typedef struct {
        logic       rd;
        logic       ad;
        logic       oe;
        logic [7:0] val;
    } stb_t;

    logic       clk = 1'b0;
    logic       rst_n;
    logic [7:0] ad_in;
    logic [7:0] ad_out, ad_out2;
    logic       ad_oe, c_s, r_d, w_r, a_d;
    logic       ad_oe2, c_s2, r_d2, w_r2, a_d2;

    always #5 clk = ~clk;

    rtc_bus_ctrl_if h1 ();
    rtc_bus_ctrl_if h2 ();

    rtc_bus_ctrl #(.T_SET(TS), .T_STB(TSB)) u_dut (
        .clk_100MHz (clk),
        .rst_n      (rst_n),
        .host       (h1),
        .ADin       (ad_in),
        .ADout      (ad_out),
        .ad_oe      (ad_oe),
        .C_S        (c_s),
        .R_D        (r_d),
        .W_R        (w_r),
        .A_D        (a_d)
    );

    rtc_bus_ctrl #(.T_SET(TS2), .T_STB(TSB2)) u_dut2 (
        .clk_100MHz (clk),
        .rst_n      (rst_n),
        .host       (h2),
        .ADin       (ad_in),
        .ADout      (ad_out2),
        .ad_oe      (ad_oe2),
        .C_S        (c_s2),
        .R_D        (r_d2),
        .W_R        (w_r2),
        .A_D        (a_d2)
    );

    int         checks = 0;
    int         failures = 0;
    int         cyc = 0;
    done_t      done_q[$];
    stb_t       stb_q[$];
    logic [7:0] adr_q[$];
    int         dq2[$];
    int         busy_from = -1;
    int         busy_to = -2;
    int         next_ok = 0;
    int         runs2 = 0;
    logic [7:0] last_rd = 8'h00;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            failures++;
            $display("FAIL %s: got %0d (0x%0h) expected %0d (0x%0h) at cycle %0d",
                     name, act, act, exp, exp, cyc);
        end
    endtask

    // Monitor for the default-timing instance.
    initial begin
        int         run_len = 0;
        int         adr_len = 0;
        logic       run_rd = 1'b0, run_ad = 1'b0, run_oe = 1'b0, run_ok = 1'b0, adr_ok = 1'b0;
        logic [7:0] run_val = 8'h00, adr_val = 8'h00, ea;
        stb_t       se;
        done_t      de;
        forever begin
            @(negedge clk);
            chk("busy", int'(h1.busy), int'(cyc >= busy_from && cyc <= busy_to));
            chk("oe_rd_excl", int'(ad_oe & ~r_d), 0);
            if (h1.done) begin
                chk("done_expected", int'(done_q.size() > 0), 1);
                if (done_q.size() > 0) begin
                    de = done_q.pop_front();
                    chk("done_cycle", cyc, de.done_cyc);
                    chk("rd_data", int'(h1.rd_data), int'(de.rd));
                end
            end
            if (!rst_n) begin
                run_len = 0;
                adr_len = 0;
            end else begin
                if (!w_r || !r_d) begin
                    chk("cs_low", int'(c_s), 0);
                    chk("wr_rd_excl", int'(!w_r && !r_d), 0);
                    if (run_len == 0) begin
                        run_rd = ~r_d; run_ad = a_d; run_oe = ad_oe; run_val = ad_out; run_ok = 1'b1;
                    end else if (run_rd != ~r_d || run_ad != a_d || run_oe != ad_oe ||
                                 run_val != ad_out) begin
                        run_ok = 1'b0;
                    end
                    run_len++;
                end else begin
                    chk("cs_high", int'(c_s), 1);
                    if (run_len > 0) begin
                        chk("strobe_expected", int'(stb_q.size() > 0), 1);
                        if (stb_q.size() > 0) begin
                            se = stb_q.pop_front();
                            chk("stb_len", run_len, TSB);
                            chk("stb_kind", int'(run_rd), int'(se.rd));
                            chk("stb_a_d", int'(run_ad), int'(se.ad));
                            chk("stb_oe", int'(run_oe), int'(se.oe));
                            chk("stb_stable", int'(run_ok), 1);
                            if (!se.rd) chk("stb_val", int'(run_val), int'(se.val));
                        end
                    end
                    run_len = 0;
                end
                // Address phase: A_D low, address driven and stable throughout.
                if (!a_d) begin
                    if (adr_len == 0) begin
                        adr_val = ad_out; adr_ok = ad_oe;
                    end else if (adr_val != ad_out || !ad_oe) begin
                        adr_ok = 1'b0;
                    end
                    adr_len++;
                end else if (adr_len > 0) begin
                    chk("adr_phase_expected", int'(adr_q.size() > 0), 1);
                    if (adr_q.size() > 0) begin
                        ea = adr_q.pop_front();
                        chk("adr_len", adr_len, 2 * TS + TSB);
                        chk("adr_val", int'(adr_val), int'(ea));
                        chk("adr_stable", int'(adr_ok), 1);
                    end
                    adr_len = 0;
                end
            end
        end
    end

    // Monitor for the short-timing instance used for back-to-back requests.
    initial begin
        int run2 = 0;
        forever begin
            @(negedge clk);
            if (h2.done) begin
                chk("b2b_done_expected", int'(dq2.size() > 0), 1);
                if (dq2.size() > 0) chk("b2b_done_cycle", cyc, dq2.pop_front());
            end
            if (!w_r2 || !r_d2) begin
                run2++;
            end else if (run2 > 0) begin
                chk("b2b_stb_len", run2, TSB2);
                runs2++;
                run2 = 0;
            end
        end
    end

    task automatic issue(input logic w, input logic [7:0] a, input logic [7:0] d,
                         input logic [7:0] din, input logic rogue, input logic [7:0] din_after,
                         input logic abort);
        int acc;
        int r;
        @(negedge clk);
        while (cyc + 1 < next_ok) @(negedge clk);
        h1.req = 1'b1; h1.wr = w; h1.addr = a; h1.wdata = d;
        ad_in = din;
        acc = cyc + 1;
        r = $urandom_range(1, TXN - 1);
        busy_from = acc;
        busy_to = acc + TXN;
        next_ok = acc + TXN + 2;
        if (!w) last_rd = din;
        done_q.push_back('{done_cyc: acc + TXN, rd: last_rd});
        stb_q.push_back('{rd: 1'b0, ad: 1'b0, oe: 1'b1, val: a});
        stb_q.push_back('{rd: ~w, ad: 1'b1, oe: w, val: d});
        adr_q.push_back(a);
        while (cyc < acc + TXN) begin
            @(negedge clk);
            h1.req = rogue && (cyc == acc + r);
            if (cyc == acc || h1.req) begin
                // Late changes must not leak into the latched transaction.
                h1.wr = 1'($urandom_range(0, 1));
                h1.addr = h1.req ? 8'h40 : 8'($urandom_range(0, 255));
                h1.wdata = 8'($urandom_range(0, 255));
            end
            if (!w && cyc == acc + CAP) ad_in = din_after;
            if (abort && cyc == acc + 3 * TS + TSB + 3) begin
                h1.req = 1'b0;
                #2 rst_n = 1'b0;
                #1;
                chk("abort_w_r", int'(w_r), 1);
                chk("abort_c_s", int'(c_s), 1);
                chk("abort_ad_oe", int'(ad_oe), 0);
                chk("abort_busy", int'(h1.busy), 0);
                done_q.delete();
                stb_q.delete();
                adr_q.delete();
                busy_to = -2;
                last_rd = 8'h00;
                repeat (2) @(negedge clk);
                #2 rst_n = 1'b1;
                next_ok = 0;
                return;
            end
        end
        h1.req = 1'b0;
    endtask

    initial begin
        int acc2;
        rst_n = 1'b0;
        ad_in = 8'h00;
        h1.req = 1'b0; h1.wr = 1'b0; h1.addr = 8'h00; h1.wdata = 8'h00;
        h2.req = 1'b0; h2.wr = 1'b0; h2.addr = 8'h00; h2.wdata = 8'h00;
        repeat (3) @(negedge clk);
        chk("rst_c_s", int'(c_s), 1);
        chk("rst_r_d", int'(r_d), 1);
        chk("rst_w_r", int'(w_r), 1);
        chk("rst_a_d", int'(a_d), 1);
        chk("rst_ad_oe", int'(ad_oe), 0);
        chk("rst_ad_out", int'(ad_out), 0);
        chk("rst_busy", int'(h1.busy), 0);
        chk("rst_done", int'(h1.done), 0);
        chk("rst_rd_data", int'(h1.rd_data), 0);
        #2 rst_n = 1'b1;

        issue(1'b1, 8'h21, 8'h35, 8'h00, 1'b0, 8'h00, 1'b0);
        issue(1'b0, 8'h22, 8'h00, 8'h12, 1'b0, 8'h55, 1'b0);
        issue(1'b1, 8'h5a, 8'hc3, 8'h00, 1'b1, 8'h00, 1'b0);
        issue(1'b0, 8'h33, 8'h00, 8'h9e, 1'b1, 8'h55, 1'b0);
        issue(1'b1, 8'h7e, 8'h11, 8'h00, 1'b0, 8'h00, 1'b1);
        chk("post_abort_rd_data", int'(h1.rd_data), 0);
        issue(1'b1, 8'h01, 8'h02, 8'h00, 1'b0, 8'h00, 1'b0);
        for (int i = 0; i < 25; i++) begin
            issue(1'($urandom_range(0, 1)), 8'($urandom_range(0, 255)),
                  8'($urandom_range(0, 255)), 8'($urandom_range(0, 255)),
                  1'($urandom_range(0, 1)), 8'($urandom_range(0, 255)), 1'b0);
            repeat ($urandom_range(0, 3)) @(negedge clk);
        end

        // Back-to-back: req held high across three acceptances.
        @(negedge clk);
        h2.req = 1'b1; h2.wr = 1'b1; h2.addr = 8'h66; h2.wdata = 8'h99;
        acc2 = cyc + 1;
        for (int i = 0; i < 3; i++) dq2.push_back(acc2 + i * (TXN2 + 2) + TXN2);
        while (cyc < acc2 + 2 * (TXN2 + 2)) @(negedge clk);
        h2.req = 1'b0;

        repeat (40) @(negedge clk);
        chk("done_q_drained", done_q.size(), 0);
        chk("stb_q_drained", stb_q.size(), 0);
        chk("adr_q_drained", adr_q.size(), 0);
        chk("b2b_done_drained", dq2.size(), 0);
        chk("b2b_strobe_count", runs2, 6);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
